// File: rtl/frame_stream_pkg.sv
// Shared types for the frame stream source: FSM states, per-pixel tags and frame sizing.
package frame_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

    localparam int unsigned TAG_W = 3;

    function automatic int unsigned frame_pixels(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO; an incoming word into an empty FIFO is
// presented on the same cycle it is written, so a read-to-valid path costs no extra cycle.
module stream_fifo2 #(
    parameter int unsigned DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic          valid,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          empty;
    logic          pop;
    logic          pop_mem;
    logic          push_mem;

    assign empty    = (count == 2'd0);
    assign valid    = !empty || wr_en;
    assign pop      = rd_en && valid;
    assign pop_mem  = pop && !empty;
    // A word popped on arrival into an empty FIFO is never stored.
    assign push_mem = wr_en && !(pop && empty);

    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data = mem[rd_ptr];
        end else if (wr_en) begin
            rd_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_mem) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push_mem) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_mem) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push_mem) - 2'(pop_mem);
        end
    end

endmodule

// File: rtl/frame_stream_source.sv
// Replays a stored greyscale frame from a synchronous image RAM as a tagged
// valid/ready pixel stream, optionally looping frame after frame.
module frame_stream_source
    import frame_stream_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned W          = 8,
    parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop_en,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_rd_data,
    output logic              x_valid,
    input  logic              x_ready,
    output logic [W-1:0]      x_data,
    output logic              x_sof,
    output logic              x_eol,
    output logic              x_eof
);

    localparam int unsigned COL_W        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned FW           = W + TAG_W;
    localparam int unsigned FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    state_t         state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic           rvalid_q;
    pix_tag_t       tag_q;
    pix_tag_t       issue_tag;
    pix_tag_t       out_tag;
    logic           issue_last;
    logic           room;
    logic           last_hs;
    logic           restart;
    logic [1:0]     fifo_count;
    logic [FW-1:0]  fifo_wr;
    logic [FW-1:0]  fifo_rd;

    // Tags for the address being issued, derived from the raster position.
    assign issue_tag.sof = (col_q == '0) && (row_q == '0);
    assign issue_tag.eol = (col_q == LAST_COL);
    assign issue_tag.eof = (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign issue_last    = (mem_addr == LAST_ADDR);

    // At most two pixels held between the RAM output and the FIFO.
    assign room      = ({1'b0, fifo_count} + 3'(rvalid_q)) < 3'd2;
    assign last_hs   = x_valid && x_ready && x_eof;
    assign restart   = (state_q == DRAIN) && last_hs && loop_en;
    assign mem_rd_en = ((state_q == FETCH) || restart) && room;

    assign frame_done = last_hs;
    assign fifo_wr    = {tag_q, mem_rd_data};
    assign {out_tag, x_data} = fifo_rd;
    assign x_sof      = out_tag.sof;
    assign x_eol      = out_tag.eol;
    assign x_eof      = out_tag.eof;

    stream_fifo2 #(
        .DW(FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rvalid_q),
        .wr_data (fifo_wr),
        .rd_en   (x_ready),
        .valid   (x_valid),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            mem_addr    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rvalid_q    <= 1'b0;
            tag_q       <= '0;
            frame_count <= 16'd0;
        end else begin
            rvalid_q <= mem_rd_en;
            if (mem_rd_en) begin
                tag_q <= issue_tag;
                // Wrapping on the last issue leaves the counters ready for a looped frame.
                if (issue_last) begin
                    mem_addr <= '0;
                    col_q    <= '0;
                    row_q    <= '0;
                end else begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    if (col_q == LAST_COL) begin
                        col_q <= '0;
                        row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
            end
            if (last_hs) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_rd_en && issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        if (!loop_en) begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end else if (!(mem_rd_en && issue_last)) begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source on a 4x3 frame whose RAM holds data = address.
module tb_frame_stream_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        loop_en;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic        x_valid;
    logic        x_ready;
    logic [7:0]  x_data;
    logic        x_sof;
    logic        x_eol;
    logic        x_eof;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_stream_source #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (3),
        .W          (8),
        .ADDR_W     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .loop_en     (loop_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .x_sof       (x_sof),
        .x_eol       (x_eol),
        .x_eof       (x_eof)
    );

    // Image RAM: one-cycle read latency, contents equal to the address.
    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= 8'(mem_addr);
        end
    end

    // Expected {data, sof, eol, eof} for raster index p of a 4x3 frame.
    function automatic logic [10:0] px(input int p);
        logic s;
        logic l;
        logic f;
        s = (p == 0);
        l = ((p % 4) == 3);
        f = (p == 11);
        return {8'(p), s, l, f};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; loop_en = 1'b0; x_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] v;
        rst = 1'b1; start = 1'b0; loop_en = 1'b0; x_ready = 1'b1;
        cyc();
        cyc();
        #1;
        v = {busy, frame_done, frame_count, mem_rd_en, mem_addr, x_valid, x_data, x_sof, x_eol, x_eof};
        total++;
        if (v !== 35'd0) begin bad++; $display("FAIL reset_outputs got %h want 0", v); end
        rst = 1'b0;
        cyc();
        #1;
        v = {busy, frame_done, frame_count, mem_rd_en, mem_addr, x_valid, x_data, x_sof, x_eol, x_eof};
        total++;
        if (v !== 35'd0) begin bad++; $display("FAIL reset_idle got %h want 0", v); end
    endtask

    task automatic test_single_frame();
        logic        exp_v;
        logic        exp_rd;
        logic [15:0] exp_fc;
        int          p;
        do_reset();
        x_ready = 1'b1; start = 1'b1;
        #1;
        total++;
        if ({x_valid, mem_rd_en, busy} !== 3'b000) begin
            bad++; $display("FAIL single_k0 got %b want 000", {x_valid, mem_rd_en, busy});
        end
        for (int k = 1; k <= 16; k++) begin
            cyc();
            start = 1'b0;
            #1;
            p = k - 2;
            exp_v  = (k >= 2) && (k <= 13);
            exp_rd = (k >= 1) && (k <= 12);
            exp_fc = (k >= 14) ? 16'd1 : 16'd0;
            total++;
            if (x_valid !== exp_v) begin bad++; $display("FAIL single_valid k=%0d got %b want %b", k, x_valid, exp_v); end
            if (exp_v) begin
                total++;
                if ({x_data, x_sof, x_eol, x_eof} !== px(p)) begin
                    bad++; $display("FAIL single_pixel k=%0d got %h want %h", k, {x_data, x_sof, x_eol, x_eof}, px(p));
                end
            end
            total++;
            if (frame_done !== (k == 13)) begin bad++; $display("FAIL single_done k=%0d got %b", k, frame_done); end
            total++;
            if (busy !== (k <= 13)) begin bad++; $display("FAIL single_busy k=%0d got %b", k, busy); end
            total++;
            if (mem_rd_en !== exp_rd) begin bad++; $display("FAIL single_rd k=%0d got %b want %b", k, mem_rd_en, exp_rd); end
            if (exp_rd) begin
                total++;
                if (mem_addr !== 4'(k - 1)) begin bad++; $display("FAIL single_addr k=%0d got %0d want %0d", k, mem_addr, k - 1); end
            end
            total++;
            if (frame_count !== exp_fc) begin bad++; $display("FAIL single_count k=%0d got %0d want %0d", k, frame_count, exp_fc); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        int          issued;
        int          acc;
        int          outst;
        logic        exp_v;
        logic        exp_rd;
        logic        hs;
        pat = 16'b0101_1100_0110_1001;
        issued = 0; acc = 0;
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 80 && acc < 12; k++) begin
            cyc();
            start = 1'b0;
            x_ready = pat[k % 16];
            #1;
            outst  = issued - acc;
            exp_rd = (issued < 12) && (outst < 2);
            exp_v  = (outst > 0);
            total++;
            if (mem_rd_en !== exp_rd) begin bad++; $display("FAIL bp_rd k=%0d got %b want %b out=%0d", k, mem_rd_en, exp_rd, outst); end
            if (exp_rd) begin
                total++;
                if (mem_addr !== 4'(issued)) begin bad++; $display("FAIL bp_addr k=%0d got %0d want %0d", k, mem_addr, issued); end
            end
            total++;
            if (x_valid !== exp_v) begin bad++; $display("FAIL bp_valid k=%0d got %b want %b", k, x_valid, exp_v); end
            if (exp_v) begin
                total++;
                if ({x_data, x_sof, x_eol, x_eof} !== px(acc)) begin
                    bad++; $display("FAIL bp_pixel k=%0d got %h want %h", k, {x_data, x_sof, x_eol, x_eof}, px(acc));
                end
            end
            hs = exp_v && x_ready;
            total++;
            if (frame_done !== (hs && acc == 11)) begin bad++; $display("FAIL bp_done k=%0d got %b", k, frame_done); end
            if (exp_rd) issued++;
            if (hs) acc++;
        end
        total++;
        if (acc != 12) begin bad++; $display("FAIL bp_timeout got %0d pixels want 12", acc); end
        cyc();
        #1;
        total++;
        if ({busy, x_valid, frame_count} !== {1'b0, 1'b0, 16'd1}) begin
            bad++; $display("FAIL bp_end got busy=%b valid=%b count=%0d want 0 0 1", busy, x_valid, frame_count);
        end
    endtask

    task automatic test_loop();
        logic        exp_v;
        logic        exp_rd;
        logic [15:0] exp_fc;
        int          p;
        do_reset();
        x_ready = 1'b1; loop_en = 1'b1; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            start = 1'b0;
            if (k == 30) loop_en = 1'b0;
            #1;
            p      = (k - 2) % 12;
            exp_v  = (k >= 2) && (k <= 37);
            exp_rd = (k >= 1) && (k <= 36);
            exp_fc = (k < 14) ? 16'd0 : (k < 26) ? 16'd1 : (k < 38) ? 16'd2 : 16'd3;
            total++;
            if (x_valid !== exp_v) begin bad++; $display("FAIL loop_valid k=%0d got %b want %b", k, x_valid, exp_v); end
            if (exp_v) begin
                total++;
                if ({x_data, x_sof, x_eol, x_eof} !== px(p)) begin
                    bad++; $display("FAIL loop_pixel k=%0d got %h want %h", k, {x_data, x_sof, x_eol, x_eof}, px(p));
                end
            end
            total++;
            if (mem_rd_en !== exp_rd) begin bad++; $display("FAIL loop_rd k=%0d got %b want %b", k, mem_rd_en, exp_rd); end
            if (exp_rd) begin
                total++;
                if (mem_addr !== 4'((k - 1) % 12)) begin bad++; $display("FAIL loop_addr k=%0d got %0d want %0d", k, mem_addr, (k - 1) % 12); end
            end
            total++;
            if (frame_done !== (exp_v && p == 11)) begin bad++; $display("FAIL loop_done k=%0d got %b", k, frame_done); end
            total++;
            if (frame_count !== exp_fc) begin bad++; $display("FAIL loop_count k=%0d got %0d want %0d", k, frame_count, exp_fc); end
            total++;
            if (busy !== (k <= 37)) begin bad++; $display("FAIL loop_busy k=%0d got %b", k, busy); end
        end
    endtask

    task automatic test_start_ignored();
        int pix;
        int rds;
        int dones;
        do_reset();
        x_ready = 1'b1; start = 1'b1;
        pix = 0; rds = 0; dones = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            start = (k <= 12);
            #1;
            if (mem_rd_en) begin
                total++;
                if (mem_addr !== 4'(rds)) begin bad++; $display("FAIL spam_addr k=%0d got %0d want %0d", k, mem_addr, rds); end
                rds++;
            end
            if (x_valid) begin
                total++;
                if (x_data !== 8'(pix)) begin bad++; $display("FAIL spam_data k=%0d got %0d want %0d", k, x_data, pix); end
                pix++;
            end
            if (frame_done) dones++;
        end
        total++;
        if (pix != 12) begin bad++; $display("FAIL spam_pixels got %0d want 12", pix); end
        total++;
        if (rds != 12) begin bad++; $display("FAIL spam_reads got %0d want 12", rds); end
        total++;
        if (dones != 1) begin bad++; $display("FAIL spam_done got %0d want 1", dones); end
        total++;
        if ({busy, frame_count} !== {1'b0, 16'd1}) begin
            bad++; $display("FAIL spam_end got busy=%b count=%0d want 0 1", busy, frame_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [34:0] v;
        do_reset();
        x_ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            start = 1'b0;
            if (k == 8) rst = 1'b1;
            #1;
            total++;
            if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_done_early k=%0d got %b", k, frame_done); end
        end
        total++;
        if ({mem_rd_en, mem_addr, x_data} !== {1'b1, 4'd7, 8'd6}) begin
            bad++; $display("FAIL mid_inflight got rd=%b addr=%0d data=%0d want 1 7 6", mem_rd_en, mem_addr, x_data);
        end
        for (int k = 9; k <= 12; k++) begin
            cyc();
            rst = 1'b0;
            #1;
            v = {busy, frame_done, frame_count, mem_rd_en, mem_addr, x_valid, x_data, x_sof, x_eol, x_eof};
            total++;
            if (v !== 35'd0) begin bad++; $display("FAIL mid_cleared k=%0d got %h want 0", k, v); end
        end
        start = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            cyc();
            start = 1'b0;
            #1;
            if (j == 1) begin
                total++;
                if ({mem_rd_en, mem_addr} !== {1'b1, 4'd0}) begin
                    bad++; $display("FAIL mid_restart_addr got rd=%b addr=%0d want 1 0", mem_rd_en, mem_addr);
                end
            end
            if (j >= 2 && j <= 13) begin
                total++;
                if ({x_valid, x_data, x_sof, x_eol, x_eof} !== {1'b1, px(j - 2)}) begin
                    bad++; $display("FAIL mid_pixel j=%0d got %h want %h", j, {x_valid, x_data, x_sof, x_eol, x_eof}, {1'b1, px(j - 2)});
                end
            end
            total++;
            if (frame_done !== (j == 13)) begin bad++; $display("FAIL mid_done j=%0d got %b", j, frame_done); end
        end
        total++;
        if (frame_count !== 16'd1) begin bad++; $display("FAIL mid_count got %0d want 1", frame_count); end
    endtask

    task automatic test_stall();
        int rds;
        int acc;
        do_reset();
        x_ready = 1'b0; start = 1'b1;
        rds = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            start = 1'b0;
            #1;
            if (mem_rd_en) begin
                total++;
                if (mem_addr !== 4'(rds)) begin bad++; $display("FAIL stall_addr k=%0d got %0d want %0d", k, mem_addr, rds); end
                rds++;
            end
            if (k >= 2) begin
                total++;
                if ({x_valid, x_data, x_sof, busy} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin
                    bad++; $display("FAIL stall_hold k=%0d got %h want %h", k, {x_valid, x_data, x_sof, busy}, {1'b1, 8'd0, 1'b1, 1'b1});
                end
            end
        end
        total++;
        if (rds != 2) begin bad++; $display("FAIL stall_reads got %0d want 2", rds); end
        acc = 0;
        for (int k = 11; k <= 50 && acc < 12; k++) begin
            cyc();
            x_ready = 1'b1;
            #1;
            if (x_valid) begin
                total++;
                if ({x_data, x_sof, x_eol, x_eof} !== px(acc)) begin
                    bad++; $display("FAIL stall_pixel k=%0d got %h want %h", k, {x_data, x_sof, x_eol, x_eof}, px(acc));
                end
                acc++;
            end
        end
        total++;
        if (acc != 12) begin bad++; $display("FAIL stall_timeout got %0d pixels want 12", acc); end
        cyc();
        #1;
        total++;
        if ({busy, frame_count} !== {1'b0, 16'd1}) begin
            bad++; $display("FAIL stall_end got busy=%b count=%0d want 0 1", busy, frame_count);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; loop_en = 1'b0; x_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_loop();
        test_start_ignored();
        test_reset_mid();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Streaming transmitter for the pixel pipeline: reads a stored greyscale frame from a synchronous image RAM in raster order and drives it as a valid/ready pixel stream into the convolution/edge-detection chain (the camera-side input).
- Provides frame and line markers plus frame completion status, so the pipeline can be exercised without a live camera and replayed frame after frame.

Parameters:
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- W, 8, pixel width in bits
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), image RAM address width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin a frame when idle
- loop_en  in  1  when 1 at frame end, restart immediately at address 0
- busy  out  1  high from accepted start until the last pixel handshakes (and no restart)
- frame_done  out  1  one-cycle pulse on the last-pixel handshake of every frame
- frame_count  out  16  frames completed, wraps modulo 2^16
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address, raster order
- mem_rd_data  in  W  RAM data, valid exactly 1 cycle after mem_rd_en
- x_valid  out  1  output pixel valid
- x_ready  in  1  downstream ready
- x_data  out  W  output pixel
- x_sof  out  1  qualifies x_data as pixel (0,0)
- x_eol  out  1  qualifies x_data as last pixel of a line
- x_eof  out  1  qualifies x_data as last pixel of the frame

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO emptied; in-flight read discarded; counters cleared. A reset mid-frame abandons the frame, with no frame_done.
- FSM IDLE -> FETCH on start. FETCH -> DRAIN after the read for address FRAME_PIXELS-1 issues. DRAIN -> IDLE on the last-pixel handshake, or DRAIN -> FETCH on that handshake if loop_en=1.
  - loop_en is sampled on that handshake cycle.
  - Fetching of the next frame may not begin before the handshake.
- start is ignored unless the FSM is in IDLE.
- Read issue rule: mem_rd_en=1 in FETCH iff (FIFO occupancy + reads in flight) < 2. mem_addr increments by 1 per issued read and resets to 0 at each frame start.
- Returned data, with x/y-derived sof/eol/eof tags carried alongside, is written into a 2-entry FIFO one cycle after issue.
- Stream rules:
  - x_valid = FIFO non-empty.
  - A pixel is transferred on x_valid && x_ready.
  - While x_valid && !x_ready, x_data and the tags hold stable and x_valid does not drop.
  - No combinational path from x_ready to x_valid.
- Latency: start in cycle 0 gives mem_rd_en in cycle 1 and x_valid in cycle 2. With x_ready held high, sustained throughput is 1 pixel/clk with no bubbles, including across line ends and looped frame boundaries.
- Tags:
  - x_sof only on pixel 0.
  - x_eol when column == IMG_WIDTH-1.
  - x_eof only on pixel FRAME_PIXELS-1, which also carries x_eol.
  - For IMG_WIDTH=1, every pixel has x_eol.
- frame_done and the frame_count increment occur in the same cycle as the eof handshake. busy falls the cycle after, unless looping.
- Column/row counters wrap to 0 at IMG_WIDTH-1 and IMG_HEIGHT-1 respectively.
- Widths: column counter is $clog2(IMG_WIDTH), row counter is $clog2(IMG_HEIGHT), with no truncation at power-of-two sizes.

Decomposition:
- Package frame_stream_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN)
  - the FRAME_PIXELS localparam function
  - the pixel-tag struct {sof, eol, eof}
- One sub-module: stream_fifo2, a 2-entry, W+3 bit, first-word-fall-through FIFO with count output. It is reusable for other pipeline sources.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, RAM preloaded with data = address):
- Start pulse with x_ready=1 -> x_valid first high 2 cycles after start; data 0..11 on consecutive cycles; sof on 0; eol on 3, 7, 11; eof on 11; frame_done one cycle with count=1.
- x_ready toggled 1,0,0,1 pseudo-randomly -> no pixel lost or duplicated; data/tags stable while stalled; mem_rd_en never issues with occupancy+in-flight = 2.
- loop_en=1, x_ready=1 -> pixel 11 followed directly by pixel 0 (sof) with no bubble; frame_count increments 1, 2, 3.
- start asserted repeatedly mid-frame -> ignored; exactly 12 pixels per frame.
- rst asserted after pixel 5, with a read in flight -> next cycle all outputs 0; no frame_done. A subsequent start -> clean frame beginning at address 0.
- x_ready=0 throughout after start -> exactly 2 reads issued; x_valid high holding pixel 0; busy=1.
